// File: rtl/oam_arb_pkg.sv
// Shared types and constants for the OAM bus arbiter.
package oam_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        DMA   = 3'd1,
        FETCH = 3'd2,
        SCAN  = 3'd3,
        CPU   = 3'd4
    } owner_t;

    localparam logic [7:0] OAM_SIZE = 8'hA0;
    localparam logic [7:0] OPEN_BUS = 8'hFF;

endpackage

// File: rtl/oam_req_pend.sv
// Pulse-to-pending latch: captures addr/data/we on set, holds until cleared.
// cur_* bypasses a same-cycle set so a request granted on arrival uses fresh data.
module oam_req_pend (
    input  logic       clk,
    input  logic       nreset,
    input  logic       set,
    input  logic       clr,
    input  logic [7:0] addr,
    input  logic [7:0] data,
    input  logic       we,
    output logic       pend,
    output logic       ovr,
    output logic [7:0] cur_addr,
    output logic [7:0] cur_data,
    output logic       cur_we
);
    logic [7:0] addr_q;
    logic [7:0] data_q;
    logic       we_q;

    assign cur_addr = set ? addr : addr_q;
    assign cur_data = set ? data : data_q;
    assign cur_we   = set ? we   : we_q;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            pend   <= 1'b0;
            ovr    <= 1'b0;
            addr_q <= 8'h00;
            data_q <= 8'h00;
            we_q   <= 1'b0;
        end else begin
            if (set) begin
                addr_q <= addr;
                data_q <= data;
                we_q   <= we;
            end
            if (clr) begin
                pend <= 1'b0;
            end else if (set) begin
                pend <= 1'b1;
            end
            // A new byte landing on an unserviced one loses the old byte.
            if (set && pend) begin
                ovr <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/oam_bus_arbiter.sv
// Shares the OAM RAM between DMA, PPU fetch, PPU scan and CPU as two-clock
// ADDR/DATA accesses; colliding CPU accesses return open bus.
module oam_bus_arbiter
    import oam_arb_pkg::*;
(
    input  logic       clk1,
    input  logic       nreset6,
    input  logic       dma_run,
    input  logic       dma_stb,
    input  logic [7:0] dma_addr,
    input  logic [7:0] dma_data,
    input  logic       fetch_req,
    input  logic [7:0] fetch_addr,
    output logic       fetch_rdy,
    output logic [7:0] fetch_rdata,
    input  logic       scan_req,
    input  logic [5:0] scan_idx,
    output logic       scan_rdy,
    output logic [7:0] scan_y,
    output logic [7:0] scan_x,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_ack,
    output logic [7:0] cpu_rdata,
    output logic [7:0] oam_addr,
    output logic [7:0] oam_wdata,
    output logic       oam_we,
    output logic       oam_re,
    input  logic [7:0] oam_rdata,
    output owner_t     owner,
    output logic       dma_ovr,
    output state_t     fsm_state
);
    state_t     state, next_state;
    owner_t     grant, owner_q;
    logic       dma_pend, cpu_pend, cpu_ovr_unused;
    logic [7:0] dma_cur_addr, dma_cur_data, cpu_cur_addr, cpu_cur_data;
    logic       dma_cur_we, cpu_cur_we;
    logic [7:0] acc_addr, acc_wdata, sel_addr, sel_wdata, rd_val;
    logic       acc_we, acc_ok, sel_we;
    logic [5:0] scan_idx_q;
    logic       scan_second, scan_cont;
    logic       cpu_bad, cpu_accept, cpu_reject;

    assign cpu_bad    = dma_run | fetch_req | scan_req | (cpu_addr >= OAM_SIZE);
    assign cpu_accept = cpu_req & ~cpu_pend & ~cpu_bad;
    assign cpu_reject = cpu_req & ~cpu_pend & cpu_bad;
    assign scan_cont  = (state == DATA) && (owner_q == SCAN) && !scan_second;
    assign rd_val     = acc_ok ? oam_rdata : OPEN_BUS;

    oam_req_pend u_dma_pend (
        .clk(clk1), .nreset(nreset6), .set(dma_stb), .clr(grant == DMA),
        .addr(dma_addr), .data(dma_data), .we(1'b1),
        .pend(dma_pend), .ovr(dma_ovr),
        .cur_addr(dma_cur_addr), .cur_data(dma_cur_data), .cur_we(dma_cur_we)
    );

    oam_req_pend u_cpu_pend (
        .clk(clk1), .nreset(nreset6), .set(cpu_accept), .clr(grant == CPU),
        .addr(cpu_addr), .data(cpu_wdata), .we(cpu_we),
        .pend(cpu_pend), .ovr(cpu_ovr_unused),
        .cur_addr(cpu_cur_addr), .cur_data(cpu_cur_data), .cur_we(cpu_cur_we)
    );

    always_ff @(posedge clk1) begin
        if (!nreset6) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        grant      = NONE;
        if (state == IDLE || state == DATA) begin
            // An open scan burst keeps the bus for its X byte, even over DMA.
            if (scan_cont)                   grant = SCAN;
            else if (dma_pend)               grant = DMA;
            else if (fetch_req)              grant = FETCH;
            else if (scan_req)               grant = SCAN;
            else if (cpu_pend || cpu_accept) grant = CPU;
        end
        case (state)
            IDLE:    if (grant != NONE) next_state = ADDR;
            ADDR:    next_state = DATA;
            DATA:    next_state = (grant != NONE) ? ADDR : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        sel_addr  = 8'h00;
        sel_wdata = 8'h00;
        sel_we    = 1'b0;
        case (grant)
            DMA: begin
                sel_addr  = dma_cur_addr;
                sel_wdata = dma_cur_data;
                sel_we    = dma_cur_we;
            end
            FETCH: sel_addr = fetch_addr;
            SCAN:  sel_addr = scan_cont ? {scan_idx_q, 2'b01} : {scan_idx, 2'b00};
            CPU: begin
                sel_addr  = cpu_cur_addr;
                sel_wdata = cpu_cur_data;
                sel_we    = cpu_cur_we;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (!nreset6) begin
            owner_q     <= NONE;
            acc_addr    <= 8'h00;
            acc_wdata   <= 8'h00;
            acc_we      <= 1'b0;
            acc_ok      <= 1'b0;
            scan_idx_q  <= 6'd0;
            scan_second <= 1'b0;
            fetch_rdy   <= 1'b0;
            fetch_rdata <= 8'h00;
            scan_rdy    <= 1'b0;
            scan_y      <= 8'h00;
            scan_x      <= 8'h00;
            cpu_ack     <= 1'b0;
            cpu_rdata   <= 8'h00;
        end else begin
            fetch_rdy <= 1'b0;
            scan_rdy  <= 1'b0;
            cpu_ack   <= 1'b0;
            if (cpu_reject) begin
                cpu_ack   <= 1'b1;
                cpu_rdata <= OPEN_BUS;
            end
            if (state == DATA) begin
                case (owner_q)
                    FETCH: begin
                        fetch_rdy   <= 1'b1;
                        fetch_rdata <= rd_val;
                    end
                    SCAN: begin
                        if (scan_second) begin
                            scan_x   <= rd_val;
                            scan_rdy <= 1'b1;
                        end else begin
                            scan_y <= rd_val;
                        end
                    end
                    CPU: begin
                        cpu_ack <= 1'b1;
                        if (!acc_we) cpu_rdata <= rd_val;
                    end
                    default: ;
                endcase
            end
            if (grant != NONE) begin
                owner_q     <= grant;
                acc_addr    <= sel_addr;
                acc_wdata   <= sel_wdata;
                acc_we      <= sel_we;
                acc_ok      <= (sel_addr < OAM_SIZE);
                scan_second <= scan_cont;
                if (grant == SCAN && !scan_cont) scan_idx_q <= scan_idx;
            end else if (state == DATA) begin
                owner_q     <= NONE;
                scan_second <= 1'b0;
            end
        end
    end

    // Strobes are gated by reset so an aborted access never touches the RAM.
    assign oam_we    = nreset6 & (state == DATA) & acc_ok & acc_we;
    assign oam_re    = nreset6 & (state == DATA) & acc_ok & ~acc_we;
    assign oam_addr  = acc_addr;
    assign oam_wdata = acc_wdata;
    assign owner     = owner_q;
    assign fsm_state = state;

endmodule

// File: doc/oam_bus_arbiter.md
# oam_bus_arbiter

Sequences and shares the 160-byte OAM bus between four requesters: the OAM DMA engine, PPU sprite fetch (mode 3), PPU sprite scan (mode 2) and the CPU. It sits between the DMA block's byte output and the OAM RAM. It converts each granted request into a two-clock ADDR/DATA access and returns read data or acks to the owner. CPU accesses that collide with DMA or PPU use are rejected with DMG semantics: reads return 0xFF and writes are dropped.

## Interface
- No parameters; OAM size fixed at 160 bytes (addresses 0x00–0x9F).
- clk1  in  1  system clock; all state updates on rising edge
- nreset6  in  1  reset, synchronous, active-low
- dma_run  in  1  OAM DMA in progress (level)
- dma_stb  in  1  one-clock pulse: DMA byte ready
- dma_addr  in  8  OAM index of the DMA byte
- dma_data  in  8  DMA byte value
- fetch_req  in  1  PPU sprite-fetch request (level)
- fetch_addr  in  8  OAM address to read
- fetch_rdy  out  1  one-clock pulse: fetch_rdata valid
- fetch_rdata  out  8  fetched byte
- scan_req  in  1  PPU scan request (level)
- scan_idx  in  6  sprite index 0–39
- scan_rdy  out  1  one-clock pulse: scan_y/scan_x valid
- scan_y, scan_x  out  8 each  bytes at 4*idx and 4*idx+1
- cpu_req  in  1  one-clock pulse: CPU access
- cpu_we  in  1  write when 1
- cpu_addr  in  8  OAM address
- cpu_wdata  in  8  write data
- cpu_ack  out  1  one-clock pulse: access done or rejected
- cpu_rdata  out  8  read result
- oam_addr  out  8  RAM address
- oam_wdata  out  8  RAM write data
- oam_we, oam_re  out  1 each  RAM strobes, asserted in DATA only
- oam_rdata  in  8  RAM read data, valid during DATA
- owner  out  3  current grant (package enum)
- dma_ovr  out  1  sticky: dma_stb arrived while a DMA byte was still pending

## Operation
- FSM states: IDLE, ADDR, DATA.
  - IDLE→ADDR when any request is pending.
  - ADDR→DATA always.
  - DATA→ADDR if a request is pending (including the second scan byte), else →IDLE.
- Grant decision at IDLE/DATA exit; owner is latched for the whole access. Priority: DMA > FETCH > SCAN > CPU.
- DMA: dma_stb sets dma_pend and captures dma_addr/dma_data. dma_pend clears on entering ADDR as DMA owner. If dma_stb arrives while dma_pend=1, the new byte replaces the old one and dma_ovr is set. DMA accesses are writes.
- Scan: a two-byte burst. Address 4*idx (Y), then 4*idx+1 (X), back to back. The burst is not preemptable, even by DMA. scan_rdy fires after the X byte.
- Fetch: single-byte read. fetch_req is sampled only at grant points.
- CPU:
  - cpu_req is sampled with dma_run|fetch_req|scan_req. If any of these is high, or cpu_addr ≥ 0xA0, the access is rejected: cpu_ack on the next clock, cpu_rdata=0xFF, no RAM strobe.
  - Otherwise cpu_pend is set and serviced at lowest priority.
  - A second cpu_req while cpu_pend=1 is ignored.
- Addresses ≥ 0xA0 from DMA or fetch: access runs with no strobe; fetch returns 0xFF.
- Reset values: state IDLE, owner NONE, all pends 0, dma_ovr 0, all strobes/rdy/ack 0, all data outputs 0x00, oam_addr 0x00.
- Reset mid-access: the access aborts, no strobe, no ack/rdy, pending requests are discarded.

## Timing
- Request visible at clock N (IDLE):
  - ADDR at N+1, oam_addr driven.
  - DATA at N+2, oam_we/oam_re high for exactly one clock.
  - oam_rdata captured at the end of N+2.
  - rdy/ack at N+3.
- Throughput: one byte per 2 clocks back to back. A scan burst takes 4 clocks; scan_rdy follows at N+5.
- oam_addr and oam_wdata are stable for both ADDR and DATA.
- Simultaneous dma_stb and CPU pulse: DMA wins the grant, and the CPU is rejected because dma_run=1.

## Structure
- Package oam_arb_pkg:
  - state_t {IDLE, ADDR, DATA};
  - owner_t {NONE=0, DMA=1, FETCH=2, SCAN=3, CPU=4};
  - constants OAM_SIZE=8'hA0 and OPEN_BUS=8'hFF.
- Sub-module oam_req_pend: pulse-to-pending latch holding addr/data/we, with set/clear and an overrun output. Instantiated for DMA and CPU.

## Test plan
- Idle bus, CPU write 0x5A to 0x10, then read 0x10 → oam_we one clock at N+2, then cpu_ack with cpu_rdata=0x5A.
- dma_run=1, CPU read 0x20 → cpu_ack next clock with 0xFF; oam_re never asserted.
- 160 dma_stb pulses spaced 4 clocks apart, addr 0x00–0x9F → 160 oam_we pulses, dma_ovr=0; a second dma_stb 1 clock after the first → dma_ovr=1.
- scan_idx=5 with RAM[0x14]=0x30, RAM[0x15]=0x18 → oam_addr 0x14 then 0x15, scan_rdy at N+5, scan_y=0x30, scan_x=0x18.
- dma_stb during the first byte of a scan burst → scan completes both bytes, then the DMA write follows directly.
- nreset6 low during DATA of a CPU read → no cpu_ack; all outputs at reset values on the next clock.
